// File: rtl/ch_frame_gen.sv
// ch_frame_gen: frame/channel timing master for the FMULT+ACCUM channel pipeline.
// Generates the input and output channel clocks and frame syncs, with the output
// frame lagging the input frame by OUT_LAG_CH slots, and watches FA_done so that
// slots without exactly one MAC result raise a sticky error flag.
module ch_frame_gen #(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned CLKS_PER_CH = 64,
    parameter int unsigned CH_HIGH     = 16,
    parameter int unsigned OUT_PHASE   = 8,
    parameter int unsigned OUT_LAG_CH  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      FA_done,
    input  logic                      clr_err,
    output logic                      FSYNC_IN,
    output logic                      NOT_CH_CLK_IN,
    output logic                      FSYNC_OUT,
    output logic                      CH_CLK_OUT,
    output logic [$clog2(NUM_CH)-1:0] ch_in_idx,
    output logic [$clog2(NUM_CH)-1:0] ch_out_idx,
    output logic                      running,
    output logic                      err_missed,
    output logic                      err_double
);

    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam int unsigned SW   = $clog2(CLKS_PER_CH);

    localparam logic [SW-1:0]   SLOT_LAST = SW'(CLKS_PER_CH - 1);
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0] LAG       = CH_W'(OUT_LAG_CH);
    localparam logic [CH_W-1:0] LAG_LAST  = CH_W'(OUT_LAG_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [CH_W-1:0] lag_q, lag_d;
    logic            primed_q, primed_d;
    logic            fa_prev_q;
    logic [1:0]      fa_cnt_q, fa_cnt_d;
    logic            active, wrap, rise;
    logic            set_missed, set_double;

    logic            out_active;
    logic [31:0]     slot_ext;
    logic [CH_W-1:0] ch_out_d;
    logic            fsync_in_d, nclk_in_d, fsync_out_d, clk_out_d;
    logic            missed_d, double_d;

    // Next-state logic: FSM transitions, slot/channel counters, priming and FA_done tally.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        ch_d       = ch_q;
        lag_d      = lag_q;
        primed_d   = primed_q;
        fa_cnt_d   = fa_cnt_q;
        set_missed = 1'b0;
        set_double = 1'b0;
        active     = (state_q != IDLE);
        wrap       = active && (slot_q == SLOT_LAST);
        rise       = FA_done && !fa_prev_q;

        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                if (enable)
                    state_d = RUN;
                else if (wrap && (ch_q == CH_LAST))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (active) begin
            slot_d = wrap ? '0 : slot_q + SW'(1);
            if (wrap) begin
                ch_d       = ch_q + CH_W'(1);
                set_missed = (fa_cnt_q == 2'd0);
                set_double = (fa_cnt_q == 2'd2);
                fa_cnt_d   = rise ? 2'd1 : 2'd0;
                if (!primed_q) begin
                    lag_d = lag_q + CH_W'(1);
                    if (lag_q == LAG_LAST) primed_d = 1'b1;
                end
            end else if (rise && (fa_cnt_q != 2'd2)) begin
                fa_cnt_d = fa_cnt_q + 2'd1;
            end
        end

        if (state_d == IDLE) begin
            slot_d   = '0;
            ch_d     = '0;
            lag_d    = '0;
            primed_d = 1'b0;
            fa_cnt_d = 2'd0;
        end
    end

    // Output decode from next-state values so every output leaves a flop.
    always_comb begin
        out_active  = (state_d != IDLE);
        slot_ext    = 32'(slot_d);
        ch_out_d    = out_active ? (ch_d - LAG) : '0;
        nclk_in_d   = out_active && (slot_ext < CH_HIGH);
        fsync_in_d  = out_active && (ch_d == '0);
        clk_out_d   = out_active && primed_d && (slot_ext >= OUT_PHASE)
                      && (slot_ext < OUT_PHASE + CH_HIGH);
        fsync_out_d = out_active && primed_d && (ch_out_d == CH_LAST);
        missed_d    = set_missed || (err_missed && !clr_err);
        double_d    = set_double || (err_double && !clr_err);
    end

    // Internal state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            ch_q      <= '0;
            lag_q     <= '0;
            primed_q  <= 1'b0;
            fa_prev_q <= 1'b0;
            fa_cnt_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            ch_q      <= ch_d;
            lag_q     <= lag_d;
            primed_q  <= primed_d;
            fa_prev_q <= FA_done;
            fa_cnt_q  <= fa_cnt_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            FSYNC_IN      <= 1'b0;
            NOT_CH_CLK_IN <= 1'b0;
            FSYNC_OUT     <= 1'b0;
            CH_CLK_OUT    <= 1'b0;
            ch_in_idx     <= '0;
            ch_out_idx    <= '0;
            running       <= 1'b0;
            err_missed    <= 1'b0;
            err_double    <= 1'b0;
        end else begin
            FSYNC_IN      <= fsync_in_d;
            NOT_CH_CLK_IN <= nclk_in_d;
            FSYNC_OUT     <= fsync_out_d;
            CH_CLK_OUT    <= clk_out_d;
            ch_in_idx     <= ch_d;
            ch_out_idx    <= ch_out_d;
            running       <= out_active;
            err_missed    <= missed_d;
            err_double    <= double_d;
        end
    end

endmodule

// File: tb/tb_ch_frame_gen.sv
// tb_ch_frame_gen: randomized self-checking bench for ch_frame_gen with a
// time-based reference model (position in the run derived from a cycle count).
module tb_ch_frame_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       FA_done = 1'b0;
    logic       clr_err = 1'b0;
    logic       FSYNC_IN, NOT_CH_CLK_IN, FSYNC_OUT, CH_CLK_OUT;
    logic [2:0] ch_in_idx, ch_out_idx;
    logic       running, err_missed, err_double;

    int checks = 0;
    int failures = 0;

    // Reference model: m_t is cycles elapsed since the run left IDLE.
    bit m_active, m_drain, m_faprev, m_miss, m_dbl;
    int m_t, m_fcnt;

    // FA_done pulse plan for the current slot.
    int planK, planP1, planP2;
    bit curEn;
    int firstClk, firstFs;

    ch_frame_gen #(
        .NUM_CH(8), .CLKS_PER_CH(64), .CH_HIGH(16), .OUT_PHASE(8), .OUT_LAG_CH(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .FA_done(FA_done), .clr_err(clr_err),
        .FSYNC_IN(FSYNC_IN), .NOT_CH_CLK_IN(NOT_CH_CLK_IN), .FSYNC_OUT(FSYNC_OUT),
        .CH_CLK_OUT(CH_CLK_OUT), .ch_in_idx(ch_in_idx), .ch_out_idx(ch_out_idx),
        .running(running), .err_missed(err_missed), .err_double(err_double)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reportTimeout(input string tag);
        checks++;
        failures++;
        $display("[TB] FAIL %s: observed=timeout expected=event", tag);
    endtask

    function automatic logic [31:0] dutVec();
        return 32'({running, err_double, err_missed, FSYNC_IN, NOT_CH_CLK_IN,
                    FSYNC_OUT, CH_CLK_OUT, ch_in_idx, ch_out_idx});
    endfunction

    function automatic logic [31:0] expVec();
        int  slot, n, ch, cho;
        bit  primed, fsIn, nclk, fsOut, clkOut;
        if (!m_active) return 32'({1'b0, m_dbl, m_miss, 10'b0});
        slot   = m_t % 64;
        n      = m_t / 64;
        ch     = n % 8;
        cho    = (ch + 8 - 2) % 8;
        primed = (n >= 2);
        fsIn   = (ch == 0);
        nclk   = (slot < 16);
        fsOut  = primed && (cho == 7);
        clkOut = primed && (slot >= 8) && (slot < 24);
        return 32'({1'b1, m_dbl, m_miss, fsIn, nclk, fsOut, clkOut, 3'(ch), 3'(cho)});
    endfunction

    function automatic void modelReset();
        m_active = 0; m_drain = 0; m_faprev = 0; m_miss = 0; m_dbl = 0;
        m_t = 0; m_fcnt = 0;
    endfunction

    function automatic void modelStep();
        int slot, ch;
        bit eos, rise, setm, setd;
        rise = FA_done && !m_faprev;
        if (!m_active) begin
            if (clr_err) begin m_miss = 0; m_dbl = 0; end
            if (enable) begin
                m_active = 1; m_t = 0; m_drain = 0; m_fcnt = 0;
            end
        end else begin
            slot = m_t % 64;
            ch   = (m_t / 64) % 8;
            eos  = (slot == 63);
            setm = eos && (m_fcnt == 0);
            setd = eos && (m_fcnt >= 2);
            if (eos) m_fcnt = rise ? 1 : 0;
            else if (rise && m_fcnt < 2) m_fcnt++;
            if (setm) m_miss = 1; else if (clr_err) m_miss = 0;
            if (setd) m_dbl = 1;  else if (clr_err) m_dbl = 0;
            if (m_drain && !enable && eos && ch == 7) begin
                m_active = 0; m_t = 0; m_fcnt = 0;
            end else begin
                m_drain = !enable;
                m_t++;
            end
        end
        m_faprev = FA_done;
    endfunction

    // One clock: drive inputs, advance model at the edge, compare at the falling edge.
    task automatic applyStimulus(input bit en, input bit fa, input bit clr);
        enable  = en;
        FA_done = fa;
        clr_err = clr;
        @(posedge clk);
        if (reset) modelStep();
        @(negedge clk);
        checkOutput("cycle", dutVec(), expVec());
    endtask

    // mode: 0 no FA_done pulse, 1 one pulse, 2 two pulses, 3 random mix per slot.
    task automatic stepOne(input int mode, input int clrPer1000);
        int s, r;
        bit fa, clr;
        s = m_active ? m_t % 64 : 0;
        if (s == 0) begin
            case (mode)
                0: planK = 0;
                1: planK = 1;
                2: planK = 2;
                default: begin
                    r = $urandom_range(0, 9);
                    planK = (r == 0) ? 0 : (r == 1) ? 2 : 1;
                end
            endcase
            planP1 = $urandom_range(2, 20);
            planP2 = $urandom_range(30, 50);
        end
        fa  = (planK >= 1 && s >= planP1 && s < planP1 + 3) ||
              (planK == 2 && s >= planP2 && s < planP2 + 3);
        clr = ($urandom_range(0, 999) < clrPer1000);
        applyStimulus(curEn, fa, clr);
    endtask

    task automatic runUntil(input int ch, input int s, input int mode, input int bound, input string tag);
        bit found;
        found = 0;
        for (int k = 0; k < bound; k++) begin
            if (m_active && (ch < 0 || (m_t / 64) % 8 == ch) && (m_t % 64) == s) begin
                found = 1;
                break;
            end
            stepOne(mode, 0);
        end
        if (!found) reportTimeout(tag);
    endtask

    task automatic runFromIdle(input int n);
        firstClk = -1;
        firstFs  = -1;
        for (int k = 0; k < n; k++) begin
            stepOne(1, 0);
            if (k == 0) checkOutput("restart_ch0", 32'({FSYNC_IN, NOT_CH_CLK_IN, ch_in_idx}), 32'b11000);
            if (CH_CLK_OUT && firstClk < 0) firstClk = k;
            if (FSYNC_OUT && firstFs < 0) firstFs = k;
        end
    endtask

    initial begin
        int k;
        modelReset();
        planK = 0; planP1 = 2; planP2 = 30; curEn = 0;

        repeat (3) applyStimulus(0, 0, 0);
        checkOutput("reset_state", dutVec(), 32'h0);

        // Free run from reset: channel stepping, first output strobes, no errors.
        reset = 1'b1;
        curEn = 1;
        runFromIdle(1200);
        checkOutput("first_ch_clk_out", 32'(firstClk), 32'd136);
        checkOutput("first_fsync_out", 32'(firstFs), 32'd576);
        checkOutput("err_none", 32'({err_double, err_missed}), 32'b00);

        // Skipped result, then doubled results, then clear.
        for (int i = 0; i < 130; i++) stepOne(0, 0);
        checkOutput("err_missed_set", 32'({err_double, err_missed}), 32'b01);
        for (int i = 0; i < 200; i++) stepOne(2, 0);
        checkOutput("err_double_set", 32'(err_double), 32'd1);
        applyStimulus(1, 0, 1);
        checkOutput("err_clr", 32'({err_double, err_missed}), 32'b00);

        // Clear coinciding with a missed-slot wrap: the set wins.
        runUntil(-1, 0, 1, 200, "t6_align");
        planK = 0;
        applyStimulus(1, 0, 1);
        for (int i = 0; i < 62; i++) stepOne(0, 0);
        checkOutput("t6_pre", 32'({err_double, err_missed}), 32'b00);
        applyStimulus(1, 0, 1);
        checkOutput("clr_vs_set", 32'(err_missed), 32'd1);

        // Drop enable during ch 3 at slot cycle 10: frame completes, then idle.
        runUntil(3, 10, 1, 700, "t4_align");
        curEn = 0;
        k = 0;
        while (running && k < 1000) begin
            stepOne(1, 0);
            k++;
        end
        if (k >= 1000) reportTimeout("t4_drain");
        checkOutput("drain_length", 32'(k), 32'd310);

        // Drop during ch 3, re-raise during ch 5: no gap.
        curEn = 1;
        runUntil(3, 10, 1, 1000, "t4b_align");
        curEn = 0;
        runUntil(5, 0, 1, 300, "t4b_ch5");
        curEn = 1;
        for (int i = 0; i < 400; i++) stepOne(1, 0);
        checkOutput("drain_resume", 32'(running), 32'd1);

        // Asynchronous reset mid-frame, then restart and re-prime.
        runUntil(4, 29, 1, 1000, "t5_align");
        @(posedge clk);
        modelStep();
        #2 reset = 1'b0;
        modelReset();
        #1 checkOutput("async_reset", dutVec(), 32'h0);
        repeat (3) applyStimulus(1, 0, 0);
        reset = 1'b1;
        runFromIdle(300);
        checkOutput("reprime_ch_clk_out", 32'(firstClk), 32'd136);

        // Randomized enable, FA_done and clear traffic.
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 299) == 0) curEn = !curEn;
            stepOne(3, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
